// File: rtl/switch_allocator_if.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator_if
// Description : Request/grant bundle between the input ports, the switch
//               allocator and the crossbar of one router.
//               master : input-port side, drives requests and flow control.
//               slave  : allocator side, drives the read selects and the
//                        crossbar selects.
// Signals     : request_i       [PORT_NUM][VC_NUM]       VC has a flit + dVC
//               out_port_i      [PORT_NUM][VC_NUM] port  routed output port
//               downstream_vc_i [PORT_NUM][VC_NUM] vc    owned downstream VC
//               on_off_i        [PORT_NUM][VC_NUM]       1 = downstream may accept
//               valid_sel_o     [PORT_NUM]               input port granted
//               vc_sel_o        [PORT_NUM] vc            granted VC per input
//               xbar_sel_o      [PORT_NUM] port          source input per output
//               valid_flit_o    [PORT_NUM]               output carries a flit
// Revision    : 1.0 - initial release
// ============================================================================
interface switch_allocator_if #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2
);
  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  logic [PORT_NUM-1:0][VC_NUM-1:0]         request_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PW-1:0] out_port_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VW-1:0] downstream_vc_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]         on_off_i;

  logic [PORT_NUM-1:0]                     valid_sel_o;
  logic [PORT_NUM-1:0][VW-1:0]             vc_sel_o;
  logic [PORT_NUM-1:0][PW-1:0]             xbar_sel_o;
  logic [PORT_NUM-1:0]                     valid_flit_o;

  modport master (
    output request_i,
    output out_port_i,
    output downstream_vc_i,
    output on_off_i,
    input  valid_sel_o,
    input  vc_sel_o,
    input  xbar_sel_o,
    input  valid_flit_o
  );

  modport slave (
    input  request_i,
    input  out_port_i,
    input  downstream_vc_i,
    input  on_off_i,
    output valid_sel_o,
    output vc_sel_o,
    output xbar_sel_o,
    output valid_flit_o
  );
endinterface
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator
// Description : Separable input-first switch allocator. Stage 1 picks one
//               eligible VC per input port (round-robin from in_ptr), stage 2
//               picks one candidate input port per output port (round-robin
//               from out_ptr). Grants are combinational; only the round-robin
//               pointers are registered.
// Ports       : clk  - router clock
//               rst  - synchronous, active-low reset
//               sa   - switch_allocator_if.slave (requests in, grants out)
// Config      : SA_ON_OFF_EN - when defined, on_off_i of the targeted
//               output/downstream VC gates eligibility; when undefined,
//               eligibility is request_i alone and on_off_i is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2
) (
  input  logic                clk,
  input  logic                rst,
  switch_allocator_if.slave   sa
);

  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  // Round-robin pointers
  logic [PORT_NUM-1:0][VW-1:0] in_ptr_q,  in_ptr_d;
  logic [PORT_NUM-1:0][PW-1:0] out_ptr_q, out_ptr_d;

  // Eligibility and stage-1 candidates
  logic [PORT_NUM-1:0][VC_NUM-1:0] eligible;
  logic [PORT_NUM-1:0]             cand_valid;
  logic [PORT_NUM-1:0][VW-1:0]     cand_vc;
  logic [PORT_NUM-1:0][PW-1:0]     cand_op;

  // Stage-2 results
  logic [PORT_NUM-1:0]             in_grant;
  logic [PORT_NUM-1:0][VW-1:0]     in_vc;
  logic [PORT_NUM-1:0]             out_valid;
  logic [PORT_NUM-1:0][PW-1:0]     out_src;

  // --------------------------------------------------------------------------
  // Eligibility
  // --------------------------------------------------------------------------
`ifdef SA_ON_OFF_EN
  // The on/off lookup is done by comparing against every (op, dvc) pair
  // rather than indexing, so out-of-range port/VC codes simply read as "off".
  always_comb begin
    eligible = '0;
    for (int ip = 0; ip < PORT_NUM; ip++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        for (int op = 0; op < PORT_NUM; op++) begin
          for (int d = 0; d < VC_NUM; d++) begin
            if (sa.request_i[ip][v] &&
                (sa.out_port_i[ip][v] == PW'(op)) &&
                (sa.downstream_vc_i[ip][v] == VW'(d)) &&
                sa.on_off_i[op][d]) begin
              eligible[ip][v] = 1'b1;
            end
          end
        end
      end
    end
  end
`else
  // Infinite-sink mode: flow-control inputs stay on the port but are unused.
  logic unused_flow_ctrl;
  assign unused_flow_ctrl = ^{sa.on_off_i, sa.downstream_vc_i};

  always_comb begin
    eligible = sa.request_i;
  end
`endif

  // --------------------------------------------------------------------------
  // Stage 1: per input port, first eligible VC at or above in_ptr (with wrap)
  // --------------------------------------------------------------------------
  always_comb begin
    int idx;
    idx        = 0;
    cand_valid = '0;
    cand_vc    = '0;
    cand_op    = '0;
    for (int ip = 0; ip < PORT_NUM; ip++) begin
      for (int k = 0; k < VC_NUM; k++) begin
        idx = int'(in_ptr_q[ip]) + k;
        if (idx >= VC_NUM) begin
          idx = idx - VC_NUM;
        end
        if (!cand_valid[ip] && eligible[ip][idx]) begin
          cand_valid[ip] = 1'b1;
          cand_vc[ip]    = VW'(idx);
          cand_op[ip]    = sa.out_port_i[ip][idx];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: per output port, first candidate input at or above out_ptr.
  // Each input has a single candidate, so it can win at most one output.
  // --------------------------------------------------------------------------
  always_comb begin
    int idx;
    idx       = 0;
    out_valid = '0;
    out_src   = '0;
    in_grant  = '0;
    in_vc     = '0;
    for (int op = 0; op < PORT_NUM; op++) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        idx = int'(out_ptr_q[op]) + k;
        if (idx >= PORT_NUM) begin
          idx = idx - PORT_NUM;
        end
        if (!out_valid[op] && cand_valid[idx] && (cand_op[idx] == PW'(op))) begin
          out_valid[op] = 1'b1;
          out_src[op]   = PW'(idx);
          in_grant[idx] = 1'b1;
          in_vc[idx]    = cand_vc[idx];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: forced to zero while reset is asserted
  // --------------------------------------------------------------------------
  always_comb begin
    sa.valid_sel_o  = '0;
    sa.vc_sel_o     = '0;
    sa.valid_flit_o = '0;
    sa.xbar_sel_o   = '0;
    if (rst) begin
      sa.valid_sel_o  = in_grant;
      sa.vc_sel_o     = in_vc;
      sa.valid_flit_o = out_valid;
      sa.xbar_sel_o   = out_src;
    end
  end

  // --------------------------------------------------------------------------
  // Pointer next state: advance past the winner; losers keep their pointer
  // --------------------------------------------------------------------------
  always_comb begin
    in_ptr_d  = in_ptr_q;
    out_ptr_d = out_ptr_q;
    for (int ip = 0; ip < PORT_NUM; ip++) begin
      if (in_grant[ip]) begin
        if (int'(in_vc[ip]) == VC_NUM - 1) begin
          in_ptr_d[ip] = '0;
        end else begin
          in_ptr_d[ip] = VW'(int'(in_vc[ip]) + 1);
        end
      end
    end
    for (int op = 0; op < PORT_NUM; op++) begin
      if (out_valid[op]) begin
        if (int'(out_src[op]) == PORT_NUM - 1) begin
          out_ptr_d[op] = '0;
        end else begin
          out_ptr_d[op] = PW'(int'(out_src[op]) + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_ptr_q  <= '0;
      out_ptr_q <= '0;
    end else begin
      in_ptr_q  <= in_ptr_d;
      out_ptr_q <= out_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_allocator
// Description : Directed self-checking bench for switch_allocator with
//               PORT_NUM=5, VC_NUM=2. Expected grants are hand-derived.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;

  localparam int PORT_NUM = 5;
  localparam int VC_NUM   = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  switch_allocator_if #(.PORT_NUM(PORT_NUM), .VC_NUM(VC_NUM)) sa_if ();

  switch_allocator #(.PORT_NUM(PORT_NUM), .VC_NUM(VC_NUM)) dut (
    .clk (clk),
    .rst (rst),
    .sa  (sa_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sa_if.request_i       = '0;
    sa_if.out_port_i      = '0;
    sa_if.downstream_vc_i = '0;
    sa_if.on_off_i        = '1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    sa_if.request_i = '1;
    for (int ip = 0; ip < PORT_NUM; ip++)
      for (int v = 0; v < VC_NUM; v++)
        sa_if.out_port_i[ip][v] = 3'((ip + 1) % PORT_NUM);
    #1;
    n_checks++;
    if (sa_if.valid_sel_o !== 5'b0) $display("FAIL reset_valid_sel got %b expected 00000", sa_if.valid_sel_o);
    else n_pass++;
    n_checks++;
    if (sa_if.vc_sel_o !== '0) $display("FAIL reset_vc_sel got %b expected 0", sa_if.vc_sel_o);
    else n_pass++;
    n_checks++;
    if (sa_if.valid_flit_o !== 5'b0) $display("FAIL reset_valid_flit got %b expected 00000", sa_if.valid_flit_o);
    else n_pass++;
    n_checks++;
    if (sa_if.xbar_sel_o !== '0) $display("FAIL reset_xbar_sel got %b expected 0", sa_if.xbar_sel_o);
    else n_pass++;
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (sa_if.valid_sel_o[0] !== 1'b1) $display("FAIL reset_first_grant_ip0 got %b expected 1", sa_if.valid_sel_o[0]);
    else n_pass++;
    n_checks++;
    if (sa_if.vc_sel_o[0] !== 1'b0) $display("FAIL reset_first_vc_ip0 got %0d expected 0", sa_if.vc_sel_o[0]);
    else n_pass++;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single_request();
    clear_inputs();
    do_reset();
    sa_if.request_i[1][1]       = 1'b1;
    sa_if.out_port_i[1][1]      = 3'd4;
    sa_if.downstream_vc_i[1][1] = 1'b0;
    #1;
    n_checks++;
    if (sa_if.valid_sel_o !== 5'b00010) $display("FAIL single_valid_sel got %b expected 00010", sa_if.valid_sel_o);
    else n_pass++;
    n_checks++;
    if (sa_if.vc_sel_o[1] !== 1'b1) $display("FAIL single_vc_sel got %0d expected 1", sa_if.vc_sel_o[1]);
    else n_pass++;
    n_checks++;
    if (sa_if.valid_flit_o !== 5'b10000) $display("FAIL single_valid_flit got %b expected 10000", sa_if.valid_flit_o);
    else n_pass++;
    n_checks++;
    if (sa_if.xbar_sel_o[4] !== 3'd1) $display("FAIL single_xbar_sel got %0d expected 1", sa_if.xbar_sel_o[4]);
    else n_pass++;
    tick();
    // in_ptr[1] should have wrapped to 0, so VC0 now wins over VC1
    sa_if.request_i[1][0]  = 1'b1;
    sa_if.out_port_i[1][0] = 3'd4;
    #1;
    n_checks++;
    if (sa_if.vc_sel_o[1] !== 1'b0 || sa_if.valid_sel_o[1] !== 1'b1)
      $display("FAIL single_ptr_wrap got vc=%0d valid=%b expected vc=0 valid=1", sa_if.vc_sel_o[1], sa_if.valid_sel_o[1]);
    else n_pass++;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_output_contention();
    int exp_src [6];
    int grants  [PORT_NUM];
    exp_src = '{0, 2, 3, 0, 2, 3};
    for (int i = 0; i < PORT_NUM; i++) grants[i] = 0;
    clear_inputs();
    do_reset();
    sa_if.request_i[0][0] = 1'b1; sa_if.out_port_i[0][0] = 3'd4;
    sa_if.request_i[2][0] = 1'b1; sa_if.out_port_i[2][0] = 3'd4;
    sa_if.request_i[3][0] = 1'b1; sa_if.out_port_i[3][0] = 3'd4;
    #1;
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (sa_if.valid_flit_o[4] !== 1'b1 || sa_if.xbar_sel_o[4] !== 3'(exp_src[c]))
        $display("FAIL contention_cycle%0d got valid=%b src=%0d expected valid=1 src=%0d",
                 c, sa_if.valid_flit_o[4], sa_if.xbar_sel_o[4], exp_src[c]);
      else n_pass++;
      n_checks++;
      if (sa_if.valid_sel_o !== 5'(1 << exp_src[c]))
        $display("FAIL contention_sel_cycle%0d got %b expected %b", c, sa_if.valid_sel_o, 5'(1 << exp_src[c]));
      else n_pass++;
      for (int ip = 0; ip < PORT_NUM; ip++)
        if (sa_if.valid_sel_o[ip] === 1'b1) grants[ip]++;
      tick();
    end
    n_checks++;
    if (grants[0] != 2 || grants[2] != 2 || grants[3] != 2)
      $display("FAIL contention_fairness got %0d/%0d/%0d expected 2/2/2", grants[0], grants[2], grants[3]);
    else n_pass++;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_vc_fairness();
    logic exp_vc [4];
    exp_vc = '{1'b0, 1'b1, 1'b0, 1'b1};
    clear_inputs();
    do_reset();
    sa_if.request_i[0] = 2'b11;
    sa_if.out_port_i[0][0] = 3'd1;
    sa_if.out_port_i[0][1] = 3'd1;
    #1;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (sa_if.vc_sel_o[0] !== exp_vc[c] || sa_if.valid_flit_o[1] !== 1'b1 || sa_if.valid_sel_o[0] !== 1'b1)
        $display("FAIL vc_fair_cycle%0d got vc=%0d flit=%b expected vc=%0d flit=1",
                 c, sa_if.vc_sel_o[0], sa_if.valid_flit_o[1], exp_vc[c]);
      else n_pass++;
      tick();
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_flow_control();
    clear_inputs();
    do_reset();
    sa_if.on_off_i[4][1]        = 1'b0;
    sa_if.request_i[2][0]       = 1'b1;
    sa_if.out_port_i[2][0]      = 3'd4;
    sa_if.downstream_vc_i[2][0] = 1'b1;
    #1;
`ifdef SA_ON_OFF_EN
    n_checks++;
    if (sa_if.valid_sel_o[2] !== 1'b0 || sa_if.valid_flit_o[4] !== 1'b0)
      $display("FAIL flow_off_masks got sel=%b flit=%b expected 0/0", sa_if.valid_sel_o[2], sa_if.valid_flit_o[4]);
    else n_pass++;
`else
    n_checks++;
    if (sa_if.valid_sel_o[2] !== 1'b1 || sa_if.valid_flit_o[4] !== 1'b1)
      $display("FAIL flow_off_ignored got sel=%b flit=%b expected 1/1", sa_if.valid_sel_o[2], sa_if.valid_flit_o[4]);
    else n_pass++;
`endif
    sa_if.on_off_i[4][1] = 1'b1;
    #1;
    n_checks++;
    if (sa_if.valid_sel_o[2] !== 1'b1 || sa_if.xbar_sel_o[4] !== 3'd2 || sa_if.valid_flit_o[4] !== 1'b1)
      $display("FAIL flow_on_grant got sel=%b src=%0d flit=%b expected 1/2/1",
               sa_if.valid_sel_o[2], sa_if.xbar_sel_o[4], sa_if.valid_flit_o[4]);
    else n_pass++;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_mid_reset();
    clear_inputs();
    do_reset();
    sa_if.request_i[0][0] = 1'b1; sa_if.out_port_i[0][0] = 3'd4;
    sa_if.request_i[2][0] = 1'b1; sa_if.out_port_i[2][0] = 3'd4;
    sa_if.request_i[3][0] = 1'b1; sa_if.out_port_i[3][0] = 3'd4;
    #1;
    n_checks++;
    if (sa_if.xbar_sel_o[4] !== 3'd0) $display("FAIL midrst_pre0 got %0d expected 0", sa_if.xbar_sel_o[4]);
    else n_pass++;
    tick();
    n_checks++;
    if (sa_if.xbar_sel_o[4] !== 3'd2) $display("FAIL midrst_pre1 got %0d expected 2", sa_if.xbar_sel_o[4]);
    else n_pass++;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (sa_if.valid_sel_o !== 5'b0 || sa_if.valid_flit_o !== 5'b0 || sa_if.xbar_sel_o !== '0 || sa_if.vc_sel_o !== '0)
      $display("FAIL midrst_outputs got sel=%b flit=%b expected 00000/00000", sa_if.valid_sel_o, sa_if.valid_flit_o);
    else n_pass++;
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (sa_if.valid_flit_o[4] !== 1'b1 || sa_if.xbar_sel_o[4] !== 3'd0)
      $display("FAIL midrst_post got flit=%b src=%0d expected 1/0", sa_if.valid_flit_o[4], sa_if.xbar_sel_o[4]);
    else n_pass++;
    tick();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    clear_inputs();
    test_reset();
    test_single_request();
    test_output_contention();
    test_vc_fairness();
    test_flow_control();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/switch_allocator.md
# switch_allocator

Per-router switch allocator for the mesh NoC. Every cycle it chooses at most one virtual channel per input port and at most one input port per output port. It drives the per-input-port read selection (valid_sel/vc_sel) into the input ports and the per-output-port select/valid into the crossbar. Allocation is separable input-first, with round-robin fairness at both stages and on/off flow control from downstream buffers.

## Interface

Parameters:
- PORT_NUM, default 5: router ports (LOCAL, NORTH, SOUTH, WEST, EAST), indexed by port_t encoding.
- VC_NUM, default 2: virtual channels per port.

Ports:
- clk  in  1  router clock.
- rst  in  1  reset; one clock; reset is synchronous and active-low (rst=0 resets on the rising edge of clk).
- request_i  in  [PORT_NUM][VC_NUM]  input VC holds a flit and owns a downstream VC.
- out_port_i  in  [PORT_NUM][VC_NUM] port_t  routed output port of each input VC.
- downstream_vc_i  in  [PORT_NUM][VC_NUM][$clog2(VC_NUM)]  allocated downstream VC of each input VC.
- on_off_i  in  [PORT_NUM][VC_NUM]  per output port and downstream VC; 1 = may send.
- valid_sel_o  out  [PORT_NUM]  input port granted this cycle.
- vc_sel_o  out  [PORT_NUM][$clog2(VC_NUM)]  granted VC of each input port.
- xbar_sel_o  out  [PORT_NUM][$clog2(PORT_NUM)]  input port routed to each output port.
- valid_flit_o  out  [PORT_NUM]  output port carries a flit this cycle.

## Operation

- Eligibility: input VC (ip,v) is eligible iff request_i[ip][v] and on_off_i[out_port_i[ip][v]][downstream_vc_i[ip][v]].
- Stage 1: per input port, round-robin over eligible VCs. The search starts at in_ptr[ip] and proceeds upward with wrap. The result is a candidate (ip, v, out_port).
- Stage 2: per output port, round-robin over input ports whose candidate targets that port. The search starts at out_ptr[op] and proceeds upward with wrap.
- Grants: if input port ip wins output op, then valid_sel_o[ip]=1, vc_sel_o[ip]=v, valid_flit_o[op]=1, xbar_sel_o[op]=ip.
- Non-granted ports drive valid_sel_o/vc_sel_o/valid_flit_o/xbar_sel_o = 0.
- Pointer update at the clock edge, only when rst=1:
  - in_ptr[ip] becomes (v+1) mod VC_NUM when ip is granted; otherwise it holds.
  - out_ptr[op] becomes (ip+1) mod PORT_NUM when valid_flit_o[op]=1; otherwise it holds.
  - An input port that loses stage 2 keeps its pointer.
- Wrap-around: a pointer at VC_NUM-1 or PORT_NUM-1 advances to 0.
- U-turn requests (out_port equal to the input port) are allocated like any other request; routing is responsible for preventing them.
- The allocator keeps no per-packet state. Wormhole ordering is maintained by the VC allocator holding downstream VC ownership.

## Timing

- Grant outputs are combinational from the inputs and pointer state, in the same cycle as the request. The input port reads its buffer and the crossbar transfers in that cycle.
- Throughput: at most one grant per input port and per output port each cycle. Sustained one flit/cycle per port pair.
- on_off_i dropping to 0 masks the affected requests in that same cycle. There is no skid; buffer thresholds account for in-flight flits.
- Reset values:
  - While rst=0, every output is forced to 0 regardless of requests.
  - in_ptr and out_ptr are 0 after the first rising edge with rst=0.
  - Reset asserted mid-operation discards any pending arbitration history.
- Requests withdrawn mid-cycle: the outputs follow the inputs combinationally. The pointer captures only the grant present at the clock edge.

## Configuration

- SA_ON_OFF_EN:
  - Defined: on_off_i gates eligibility as described in Operation.
  - Undefined: on_off_i is ignored, and eligibility is request_i alone. This mode is for unit tests with infinite sinks. The port stays present but unused.

## Test plan

- Reset: rst=0 with all request_i=1 -> all outputs 0. After release, the first grant for ip0 is VC0.
- Single request: request_i[1][1]=1, out_port=EAST(4), dvc=0, on_off[4][0]=1 -> valid_sel_o[1]=1, vc_sel_o[1]=1, valid_flit_o[4]=1, xbar_sel_o[4]=1. The next cycle in_ptr[1]=0 (wrap).
- Output contention: ip0, ip2, and ip3 each request EAST continuously, with on_off all 1 -> EAST grants follow 0,2,3,0,2,3. Each ip receives exactly 1 grant per 3 cycles.
- VC fairness: ip0 VC0 and VC1 both request NORTH -> vc_sel_o[0] alternates 0,1,0,1.
- Flow control (SA_ON_OFF_EN defined): on_off[4][1]=0 with ip2 VC0 requesting EAST dvc=1 -> no grant. Setting on_off to 1 gives a grant in the same cycle. With the macro undefined, the grant occurs regardless.
- Mid-operation reset: during the round-robin scenario, pull rst=0 for 1 cycle -> outputs 0. Next grant for EAST goes to ip0.
